// File: rtl/eth_rx_parser_pkg.sv
// Shared types and constants for the GMII receive parser and the CRC-32 byte engine.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_HDR,
        ST_LEN,
        ST_PAY,
        ST_TAIL,
        ST_BAD,
        ST_DROP
    } rx_state_e;

    localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_SEED    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;

    localparam int unsigned HDR_DST_OFS   = 0;
    localparam int unsigned HDR_ETYPE_OFS = 12;
    localparam int unsigned PRE_MAX       = 7;

    localparam logic [7:0]  PRE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE  = 8'hD5;
    localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;

    // Byte idx of a MAC address in wire order (most significant byte first).
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [3:0] idx);
        logic [47:0] s;
        s = mac << {idx, 3'b000};
        return s[47:40];
    endfunction

endpackage

// File: rtl/eth_rx_parser_if.sv
// GMII receive pins and the payload/verdict stream towards state_mgr.
interface eth_rx_parser_if;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv;
    logic       gmii_rx_er;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_sof;
    logic       rx_eof;
    logic       frame_ok;
    logic       frame_err;
    logic       frame_drop;

    // PHY/consumer side
    modport master (
        output gmii_rxd, gmii_rx_dv, gmii_rx_er,
        input  rx_data, rx_ready, rx_sof, rx_eof, frame_ok, frame_err, frame_drop
    );

    // Parser side
    modport slave (
        input  gmii_rxd, gmii_rx_dv, gmii_rx_er,
        output rx_data, rx_ready, rx_sof, rx_eof, frame_ok, frame_err, frame_drop
    );
endinterface

// File: rtl/eth_rx_parser_crc32_d8.sv
// Combinational CRC-32 step over one byte, LSB first; the register is held bit-reversed
// relative to the usual right-shifting form, so a clean frame leaves 0xC704DD7B.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  d,
    output logic [31:0] crc_out
);

    always_comb begin
        logic [31:0] c;
        c = crc_in;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[31] ^ d[i]) begin
                c = {c[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_rx_parser.sv
// GMII RX frame parser: strips preamble/SFD, filters MAC and EtherType, streams the
// length-prefixed payload and issues a CRC/error verdict at frame end.
module eth_rx_parser
    import eth_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter int unsigned MAX_LEN   = 1500
) (
    input  logic           clk,
    input  logic           rst,
    eth_rx_parser_if.slave bus
);

    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
    localparam logic [3:0]  DST_FIRST = 4'(HDR_DST_OFS);
    localparam logic [3:0]  DST_LAST  = 4'(HDR_DST_OFS + 5);
    localparam logic [3:0]  ETYPE_HI  = 4'(HDR_ETYPE_OFS);
    localparam logic [3:0]  ETYPE_LO  = 4'(HDR_ETYPE_OFS + 1);
    localparam logic [3:0]  PRE_LIMIT = 4'(PRE_MAX);

    rx_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] len_q, len_d;
    logic [31:0] crc_q, crc_d;
    logic [2:0]  tail_q, tail_d;
    logic        err_q, err_d;
    logic        uni_ok_q, uni_ok_d;
    logic        bc_ok_q, bc_ok_d;
    logic        et_hi_ok_q, et_hi_ok_d;
    logic        sof_pend_q, sof_pend_d;
    logic        armed_q, armed_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_ready_q, rx_ready_d;
    logic        sof_q, sof_d;
    logic        eof_q, eof_d;
    logic        ok_q, ok_d;
    logic        ferr_q, ferr_d;
    logic        drop_q, drop_d;

    logic [7:0]  rxd;
    logic        dv;
    logic        er;
    logic [31:0] crc_next;
    logic [3:0]  dst_idx;
    logic        uni_hit;
    logic        bc_hit;
    logic [15:0] len_full;

    assign rxd = bus.gmii_rxd;
    assign dv  = bus.gmii_rx_dv;
    assign er  = bus.gmii_rx_er;

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .d       (rxd),
        .crc_out (crc_next)
    );

    assign dst_idx  = cnt_q - DST_FIRST;
    assign uni_hit  = uni_ok_q && (rxd == mac_byte(LOCAL_MAC, dst_idx));
    assign bc_hit   = bc_ok_q && (rxd == mac_byte(MAC_BCAST, dst_idx));
    assign len_full = {len_q[15:8], rxd};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        crc_d      = crc_q;
        tail_d     = tail_q;
        err_d      = err_q;
        uni_ok_d   = uni_ok_q;
        bc_ok_d    = bc_ok_q;
        et_hi_ok_d = et_hi_ok_q;
        sof_pend_d = sof_pend_q;
        // After reset the rest of an interrupted frame must not look like a new preamble.
        armed_d    = armed_q | ~dv;
        rx_data_d  = rx_data_q;
        rx_ready_d = 1'b0;
        sof_d      = 1'b0;
        eof_d      = 1'b0;
        ok_d       = 1'b0;
        ferr_d     = 1'b0;
        drop_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (armed_q && dv && rxd == PRE_BYTE) begin
                    state_d = ST_PRE;
                    cnt_d   = 4'd1;
                end
            end
            ST_PRE: begin
                if (!dv) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b1;
                end else if (rxd == PRE_BYTE) begin
                    if (cnt_q == PRE_LIMIT) state_d = ST_DROP;
                    else                    cnt_d   = cnt_q + 4'd1;
                end else if (rxd == SFD_BYTE) begin
                    state_d    = ST_HDR;
                    cnt_d      = '0;
                    crc_d      = CRC_SEED;
                    err_d      = 1'b0;
                    uni_ok_d   = 1'b1;
                    bc_ok_d    = 1'b1;
                    et_hi_ok_d = 1'b0;
                end else begin
                    state_d = ST_DROP;
                end
            end
            ST_HDR: begin
                if (!dv) begin
                    state_d = ST_IDLE;
                    ferr_d  = 1'b1;
                end else begin
                    crc_d = crc_next;
                    cnt_d = cnt_q + 4'd1;
                    if (er) err_d = 1'b1;
                    if (dst_idx < 4'd6) begin
                        uni_ok_d = uni_hit;
                        bc_ok_d  = bc_hit;
                        if (cnt_q == DST_LAST && !(uni_hit || bc_hit)) state_d = ST_DROP;
                    end
                    if (cnt_q == ETYPE_HI) et_hi_ok_d = (rxd == ETHERTYPE[15:8]);
                    if (cnt_q == ETYPE_LO) begin
                        if (et_hi_ok_q && rxd == ETHERTYPE[7:0]) begin
                            state_d = ST_LEN;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_DROP;
                        end
                    end
                end
            end
            ST_LEN: begin
                if (!dv) begin
                    state_d = ST_IDLE;
                    ferr_d  = 1'b1;
                end else begin
                    crc_d = crc_next;
                    if (er) err_d = 1'b1;
                    if (cnt_q == 4'd0) begin
                        len_d[15:8] = rxd;
                        cnt_d       = 4'd1;
                    end else if (len_full > MAX_LEN_W) begin
                        state_d = ST_BAD;
                    end else if (len_full == 16'd0) begin
                        state_d = ST_TAIL;
                        tail_d  = '0;
                    end else begin
                        state_d    = ST_PAY;
                        len_d      = len_full;
                        sof_pend_d = 1'b1;
                    end
                end
            end
            ST_PAY: begin
                if (!dv) begin
                    state_d = ST_IDLE;
                    ferr_d  = 1'b1;
                end else begin
                    crc_d      = crc_next;
                    if (er) err_d = 1'b1;
                    rx_ready_d = 1'b1;
                    rx_data_d  = rxd;
                    sof_d      = sof_pend_q;
                    sof_pend_d = 1'b0;
                    eof_d      = (len_q == 16'd1);
                    len_d      = len_q - 16'd1;
                    if (len_q == 16'd1) begin
                        state_d = ST_TAIL;
                        tail_d  = '0;
                    end
                end
            end
            ST_TAIL: begin
                if (!dv) begin
                    state_d = ST_IDLE;
                    if (crc_q == CRC_RESIDUE && !err_q && tail_q == 3'd4) ok_d = 1'b1;
                    else                                                   ferr_d = 1'b1;
                end else begin
                    crc_d = crc_next;
                    if (er) err_d = 1'b1;
                    if (tail_q != 3'd4) tail_d = tail_q + 3'd1;
                end
            end
            ST_BAD: begin
                if (!dv) begin
                    state_d = ST_IDLE;
                    ferr_d  = 1'b1;
                end
            end
            ST_DROP: begin
                if (!dv) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            crc_q      <= CRC_SEED;
            tail_q     <= '0;
            err_q      <= 1'b0;
            uni_ok_q   <= 1'b0;
            bc_ok_q    <= 1'b0;
            et_hi_ok_q <= 1'b0;
            sof_pend_q <= 1'b0;
            armed_q    <= 1'b0;
            rx_data_q  <= '0;
            rx_ready_q <= 1'b0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            ok_q       <= 1'b0;
            ferr_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            crc_q      <= crc_d;
            tail_q     <= tail_d;
            err_q      <= err_d;
            uni_ok_q   <= uni_ok_d;
            bc_ok_q    <= bc_ok_d;
            et_hi_ok_q <= et_hi_ok_d;
            sof_pend_q <= sof_pend_d;
            armed_q    <= armed_d;
            rx_data_q  <= rx_data_d;
            rx_ready_q <= rx_ready_d;
            sof_q      <= sof_d;
            eof_q      <= eof_d;
            ok_q       <= ok_d;
            ferr_q     <= ferr_d;
            drop_q     <= drop_d;
        end
    end

    assign bus.rx_data    = rx_data_q;
    assign bus.rx_ready   = rx_ready_q;
    assign bus.rx_sof     = sof_q;
    assign bus.rx_eof     = eof_q;
    assign bus.frame_ok   = ok_q;
    assign bus.frame_err  = ferr_q;
    assign bus.frame_drop = drop_q;

endmodule
